digit_chain_counter: RTL and testbench
======================================

# digit_chain_counter

Parametrised cascaded multi-digit counter with per-digit limits, up/down direction, parallel load, and a run-control state machine (idle/run/pause/done). It generalises the single-digit limit counter into a complete DIGITS-wide chain with carry and borrow generated internally. The block sits between the one-pulse/tick generators and the display driver. It is the common core for stopwatch, countdown-timer and clock designs.

## Interface
- DIGITS, 4, number of cascaded digits; digit 0 is least significant.
- WIDTH, 4, bits per digit.
- clk  in  1  global clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- tick  in  1  count strobe; one step per cycle in which it is high.
- dir  in  1  1 = count up, 0 = count down; sampled on each tick.
- start  in  1  run request, single-cycle pulse.
- pause  in  1  pause request, single-cycle pulse.
- load  in  1  parallel load strobe.
- one_shot  in  1  1 = stop at terminal value; 0 = wrap around.
- init_value  in  DIGITS*WIDTH  value applied on reset and on restart from DONE.
- load_value  in  DIGITS*WIDTH  value applied on load.
- limit  in  DIGITS*WIDTH  per-digit maximum; digit i occupies bits [i*WIDTH +: WIDTH].
- value  out  DIGITS*WIDTH  current count, registered.
- carry  out  1  one-cycle pulse on an up-count terminal event.
- borrow  out  1  one-cycle pulse on a down-count terminal event.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.

## Operation
- Reset (rst_n = 0 at a clock edge):
  - value = init_value.
  - State goes to IDLE.
  - carry, borrow, running and done all go to 0.
- States and transitions:
  - IDLE → RUN on start.
  - RUN → PAUSE on pause.
  - PAUSE → RUN on start.
  - RUN → DONE on a terminal tick when one_shot = 1.
  - DONE → RUN on start; value reloads to init_value in the same edge.
- start and pause high together: no state change.
- Priority order: rst_n > load > start/pause > tick.
- load, in any state:
  - value = load_value and the state goes to IDLE.
  - A tick in the same cycle is ignored.
- Counting happens only in RUN when tick = 1. A tick in the same cycle as the start that leaves IDLE is not counted.
- Up-count:
  - Digit i steps when tick is high and every lower digit j is >= limit_j.
  - A digit that is >= its limit wraps to 0; otherwise it increments by 1.
- Down-count:
  - Digit i steps when tick is high and every lower digit is 0.
  - A digit equal to 0 wraps to its limit; otherwise it decrements by 1.
- Terminal value:
  - Up: every digit is >= its limit.
  - Down: every digit is 0.
- Terminal tick, one_shot = 0: the whole chain wraps (up → all 0; down → all digits equal limit), and carry (up) or borrow (down) pulses.
- Terminal tick, one_shot = 1: value holds, carry or borrow pulses, and the state goes to DONE.
- A digit loaded above its limit is treated as at-limit when counting up, and decrements normally when counting down.
- A change of dir takes effect on the next tick. No other side effect.

## Timing
- value updates on the clock edge that samples tick, so it is visible 1 cycle later.
- carry and borrow:
  - Registered, asserted in the same cycle the wrapped or held value is visible.
  - Exactly 1 cycle wide.
  - Back-to-back terminal ticks give back-to-back pulses.
- running and done decode the state register; they change 1 cycle after the causing input.
- All outputs are glitch-free register outputs. No combinational path from inputs to outputs.
- init_value, load_value and limit may change at any time. They are sampled only at the edge where they are used.

## Test plan
- DIGITS=4, limit=16'h5959, load 16'h5958, start, dir=1, one_shot=0, two ticks → value 5959, then 0000 with carry high for exactly 1 cycle.
- Same limits, load 0000, start, dir=0, one_shot=0, one tick → value 5959, borrow pulses once.
- Load 0002, start, dir=0, one_shot=1, four ticks → 0001, 0000, then hold 0000 with borrow pulse and done=1; the fourth tick leaves value unchanged. Then start → value = init_value and running=1.
- RUN at 0100, pause, three ticks → value stays 0100 and running=0; start, one tick → 0101.
- Mid-run, rst_n low for 1 cycle with tick high → value = init_value, IDLE, all flags 0; load plus tick in the same cycle → value = load_value exactly.
- Load 16'h00A0 (digit 1 above limit 5), dir=1, start, tick → digit 0 = 1, no digit-1 step; then step digit 0 to 9 and tick → digit 1 wraps to 0 and digit 2 increments.

Source files
------------

// File: rtl/digit_chain_counter.sv
// digit_chain_counter: cascaded DIGITS-wide counter with per-digit limits,
// up/down direction, parallel load and an idle/run/pause/done controller.
// All outputs are taken directly from registers.
module digit_chain_counter #(
   parameter int DIGITS = 4,
   parameter int WIDTH  = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_tick,
   input  logic                      i_dir,
   input  logic                      i_start,
   input  logic                      i_pause,
   input  logic                      i_load,
   input  logic                      i_one_shot,
   input  logic [DIGITS*WIDTH-1:0]   i_init_value,
   input  logic [DIGITS*WIDTH-1:0]   i_load_value,
   input  logic [DIGITS*WIDTH-1:0]   i_limit,
   output logic [DIGITS*WIDTH-1:0]   o_value,
   output logic                      o_carry,
   output logic                      o_borrow,
   output logic                      o_running,
   output logic                      o_done
);

   localparam int VW = DIGITS * WIDTH;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [VW-1:0] r_value;
   logic [1:0]    r_state;
   logic          r_carry;
   logic          r_borrow;
   logic          r_running;
   logic          r_done;

   logic [VW-1:0] w_up_value;
   logic [VW-1:0] w_dn_value;
   logic          w_up_term;
   logic          w_dn_term;
   logic [VW-1:0] w_next_value;
   logic [1:0]    w_next_state;
   logic          w_next_carry;
   logic          w_next_borrow;

   // Ripple the step enable through the digits for both directions; a digit
   // steps only when every lower digit is at its wrap point.
   always_comb begin : chain
      logic             up_en;
      logic             dn_en;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] l;
      up_en      = 1'b1;
      dn_en      = 1'b1;
      d          = '0;
      l          = '0;
      w_up_value = r_value;
      w_dn_value = r_value;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         d = r_value[i*WIDTH +: WIDTH];
         l = i_limit[i*WIDTH +: WIDTH];
         // A digit above its limit is treated as at-limit when counting up.
         if (up_en)
            w_up_value[i*WIDTH +: WIDTH] = (d >= l) ? '0 : d + 1'b1;
         if (dn_en)
            w_dn_value[i*WIDTH +: WIDTH] = (d == '0) ? l : d - 1'b1;
         up_en = up_en && (d >= l);
         dn_en = dn_en && (d == '0);
      end
      w_up_term = up_en;
      w_dn_term = dn_en;
   end

   // Next-state decode: load, then start/pause, then tick (only in RUN).
   always_comb begin
      w_next_value  = r_value;
      w_next_state  = r_state;
      w_next_carry  = 1'b0;
      w_next_borrow = 1'b0;
      if (i_load) begin
         w_next_value = i_load_value;
         w_next_state = ST_IDLE;
      end else if (i_start && i_pause) begin
         w_next_state = r_state;
      end else if (i_start) begin
         if (r_state == ST_DONE)
            w_next_value = i_init_value;
         w_next_state = ST_RUN;
      end else if (i_pause) begin
         if (r_state == ST_RUN)
            w_next_state = ST_PAUSE;
      end else if (i_tick && (r_state == ST_RUN)) begin
         if (i_dir) begin
            if (w_up_term) begin
               w_next_carry = 1'b1;
               if (i_one_shot)
                  w_next_state = ST_DONE;
               else
                  w_next_value = w_up_value;
            end else begin
               w_next_value = w_up_value;
            end
         end else begin
            if (w_dn_term) begin
               w_next_borrow = 1'b1;
               if (i_one_shot)
                  w_next_state = ST_DONE;
               else
                  w_next_value = w_dn_value;
            end else begin
               w_next_value = w_dn_value;
            end
         end
      end
   end

   // State, value and flag registers; running/done are registered from the
   // next state so they are clean register outputs.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_value   <= i_init_value;
         r_state   <= ST_IDLE;
         r_carry   <= 1'b0;
         r_borrow  <= 1'b0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_value   <= w_next_value;
         r_state   <= w_next_state;
         r_carry   <= w_next_carry;
         r_borrow  <= w_next_borrow;
         r_running <= (w_next_state == ST_RUN);
         r_done    <= (w_next_state == ST_DONE);
      end
   end

   assign o_value   = r_value;
   assign o_carry   = r_carry;
   assign o_borrow  = r_borrow;
   assign o_running = r_running;
   assign o_done    = r_done;

endmodule

// File: tb/tb_digit_chain_counter.sv
// Bench for digit_chain_counter: directed scenarios plus a randomized run
// checked against a behavioural model of the counter.
module tb_digit_chain_counter;

   localparam int DIGITS = 4;
   localparam int WIDTH  = 4;
   localparam int VW     = DIGITS * WIDTH;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tick = 1'b0;
   logic          dir = 1'b1;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic          load = 1'b0;
   logic          one_shot = 1'b0;
   logic [VW-1:0] init_value = 16'h1234;
   logic [VW-1:0] load_value = '0;
   logic [VW-1:0] limit = 16'h5959;
   logic [VW-1:0] value;
   logic          carry;
   logic          borrow;
   logic          running;
   logic          done;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [VW-1:0] m_value;
   int            m_state;
   logic          m_carry;
   logic          m_borrow;

   digit_chain_counter #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_dir(dir),
      .i_start(start), .i_pause(pause), .i_load(load), .i_one_shot(one_shot),
      .i_init_value(init_value), .i_load_value(load_value), .i_limit(limit),
      .o_value(value), .o_carry(carry), .o_borrow(borrow),
      .o_running(running), .o_done(done)
   );

   always #5 clk = ~clk;

   // Mixed-radix add-one: each digit has radix limit+1; anything at or above
   // its limit rolls over to zero and passes the carry on.
   function automatic logic [VW-1:0] model_inc(input logic [VW-1:0] v, input logic [VW-1:0] lim);
      logic [VW-1:0] r;
      int d, l;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         d = int'(v[i*WIDTH +: WIDTH]);
         l = int'(lim[i*WIDTH +: WIDTH]);
         if (d >= l) r[i*WIDTH +: WIDTH] = '0;
         else begin
            r[i*WIDTH +: WIDTH] = WIDTH'(d + 1);
            break;
         end
      end
      return r;
   endfunction

   // Mixed-radix subtract-one: a zero digit borrows and becomes its limit.
   function automatic logic [VW-1:0] model_dec(input logic [VW-1:0] v, input logic [VW-1:0] lim);
      logic [VW-1:0] r;
      int d;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         d = int'(v[i*WIDTH +: WIDTH]);
         if (d == 0) r[i*WIDTH +: WIDTH] = lim[i*WIDTH +: WIDTH];
         else begin
            r[i*WIDTH +: WIDTH] = WIDTH'(d - 1);
            break;
         end
      end
      return r;
   endfunction

   function automatic bit model_all_at_limit(input logic [VW-1:0] v, input logic [VW-1:0] lim);
      for (int i = 0; i < DIGITS; i++)
         if (v[i*WIDTH +: WIDTH] < lim[i*WIDTH +: WIDTH]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step();
      if (!rst_n) begin
         m_value  = init_value;
         m_state  = M_IDLE;
         m_carry  = 1'b0;
         m_borrow = 1'b0;
      end else begin
         m_carry  = 1'b0;
         m_borrow = 1'b0;
         if (load) begin
            m_value = load_value;
            m_state = M_IDLE;
         end else if (start && pause) begin
            m_state = m_state;
         end else if (start) begin
            if (m_state == M_DONE) m_value = init_value;
            m_state = M_RUN;
         end else if (pause) begin
            if (m_state == M_RUN) m_state = M_PAUSE;
         end else if (tick && m_state == M_RUN) begin
            if (dir) begin
               if (model_all_at_limit(m_value, limit)) begin
                  m_carry = 1'b1;
                  if (one_shot) m_state = M_DONE;
                  else m_value = '0;
               end else m_value = model_inc(m_value, limit);
            end else begin
               if (m_value == '0) begin
                  m_borrow = 1'b1;
                  if (one_shot) m_state = M_DONE;
                  else m_value = limit;
               end else m_value = model_dec(m_value, limit);
            end
         end
      end
   endtask

   // One clock: inputs are stable across the rising edge, model advances,
   // then single-cycle strobes drop and outputs are sampled at the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      start = 1'b0;
      pause = 1'b0;
      load  = 1'b0;
   endtask

   task automatic do_load(input logic [VW-1:0] v);
      tick = 1'b0;
      load = 1'b1;
      load_value = v;
      cycle();
   endtask

   task automatic do_start();
      tick = 1'b0;
      start = 1'b1;
      cycle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      init_value = 16'h1234;
      tick = 1'b1;
      cycle();
      cycle();
      checks++;
      if (value !== 16'h1234) begin errors++; $display("FAIL reset_value got %h want 1234", value); end
      checks++;
      if ({carry, borrow, running, done} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b want 0000", {carry, borrow, running, done});
      end
      rst_n = 1'b1;
      tick = 1'b0;
      cycle();
   endtask

   task automatic test_up_wrap();
      limit = 16'h5959; dir = 1'b1; one_shot = 1'b0;
      do_load(16'h5958);
      do_start();
      checks++;
      if (running !== 1'b1) begin errors++; $display("FAIL up_running got %b want 1", running); end
      tick = 1'b1; cycle();
      checks++;
      if (value !== 16'h5959 || carry !== 1'b0) begin
         errors++; $display("FAIL up_tick1 got %h c%b want 5959 c0", value, carry);
      end
      cycle();
      checks++;
      if (value !== 16'h0000 || carry !== 1'b1) begin
         errors++; $display("FAIL up_wrap got %h c%b want 0000 c1", value, carry);
      end
      tick = 1'b0; cycle();
      checks++;
      if (value !== 16'h0000 || carry !== 1'b0) begin
         errors++; $display("FAIL up_carry_width got %h c%b want 0000 c0", value, carry);
      end
   endtask

   task automatic test_down_wrap();
      dir = 1'b0; one_shot = 1'b0;
      do_load(16'h0000);
      do_start();
      tick = 1'b1; cycle();
      checks++;
      if (value !== 16'h5959 || borrow !== 1'b1) begin
         errors++; $display("FAIL down_wrap got %h b%b want 5959 b1", value, borrow);
      end
      tick = 1'b0; cycle();
      checks++;
      if (borrow !== 1'b0) begin errors++; $display("FAIL down_borrow_width got %b want 0", borrow); end
   endtask

   task automatic test_one_shot();
      dir = 1'b0; one_shot = 1'b1; init_value = 16'h1234;
      do_load(16'h0002);
      do_start();
      tick = 1'b1; cycle();
      checks++;
      if (value !== 16'h0001) begin errors++; $display("FAIL os_tick1 got %h want 0001", value); end
      cycle();
      checks++;
      if (value !== 16'h0000 || borrow !== 1'b0) begin
         errors++; $display("FAIL os_tick2 got %h b%b want 0000 b0", value, borrow);
      end
      cycle();
      checks++;
      if (value !== 16'h0000 || borrow !== 1'b1 || done !== 1'b1 || running !== 1'b0) begin
         errors++; $display("FAIL os_terminal got %h b%b d%b r%b want 0000 b1 d1 r0", value, borrow, done, running);
      end
      cycle();
      checks++;
      if (value !== 16'h0000 || borrow !== 1'b0 || done !== 1'b1) begin
         errors++; $display("FAIL os_hold got %h b%b d%b want 0000 b0 d1", value, borrow, done);
      end
      do_start();
      checks++;
      if (value !== 16'h1234 || running !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL os_restart got %h r%b d%b want 1234 r1 d0", value, running, done);
      end
   endtask

   task automatic test_pause();
      dir = 1'b1; one_shot = 1'b0;
      do_load(16'h0100);
      do_start();
      tick = 1'b0; pause = 1'b1; cycle();
      tick = 1'b1; cycle(); cycle(); cycle();
      checks++;
      if (value !== 16'h0100 || running !== 1'b0) begin
         errors++; $display("FAIL pause_hold got %h r%b want 0100 r0", value, running);
      end
      do_start();
      tick = 1'b1; cycle();
      checks++;
      if (value !== 16'h0101 || running !== 1'b1) begin
         errors++; $display("FAIL pause_resume got %h r%b want 0101 r1", value, running);
      end
      tick = 1'b0;
   endtask

   task automatic test_reset_and_load_priority();
      dir = 1'b1; init_value = 16'h1234;
      do_load(16'h0300);
      do_start();
      tick = 1'b1; cycle();
      checks++;
      if (value !== 16'h0301) begin errors++; $display("FAIL mid_run got %h want 0301", value); end
      rst_n = 1'b0; cycle();
      checks++;
      if (value !== 16'h1234 || {carry, borrow, running, done} !== 4'b0000) begin
         errors++; $display("FAIL mid_reset got %h f%b want 1234 f0000", value, {carry, borrow, running, done});
      end
      rst_n = 1'b1;
      do_start();
      tick = 1'b1; load = 1'b1; load_value = 16'h4321; cycle();
      checks++;
      if (value !== 16'h4321 || running !== 1'b0) begin
         errors++; $display("FAIL load_tick got %h r%b want 4321 r0", value, running);
      end
      tick = 1'b0;
   endtask

   task automatic test_above_limit();
      limit = 16'h5959; dir = 1'b1; one_shot = 1'b0;
      do_load(16'h00A0);
      do_start();
      tick = 1'b1; cycle();
      checks++;
      if (value !== 16'h00A1) begin errors++; $display("FAIL above_tick1 got %h want 00A1", value); end
      for (int i = 0; i < 8; i++) cycle();
      checks++;
      if (value !== 16'h00A9) begin errors++; $display("FAIL above_walk got %h want 00A9", value); end
      cycle();
      checks++;
      if (value !== 16'h0100 || carry !== 1'b0) begin
         errors++; $display("FAIL above_ripple got %h c%b want 0100 c0", value, carry);
      end
      tick = 1'b0;
   endtask

   task automatic test_random();
      int prints = 0;
      for (int n = 0; n < 4000; n++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         load  = ($urandom_range(0, 99) < 2);
         start = ($urandom_range(0, 99) < 6);
         pause = ($urandom_range(0, 99) < 4);
         tick  = (start || pause) ? 1'b0 : ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 99) < 5) dir = ~dir;
         if ($urandom_range(0, 99) < 2) one_shot = ~one_shot;
         init_value = 16'($urandom);
         load_value = 16'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            for (int i = 0; i < DIGITS; i++)
               limit[i*WIDTH +: WIDTH] = 4'($urandom_range(0, 9));
         end
         cycle();
         checks++;
         if (value !== m_value || carry !== m_carry || borrow !== m_borrow ||
             running !== (m_state == M_RUN) || done !== (m_state == M_DONE)) begin
            errors++;
            if (prints < 20) begin
               prints++;
               $display("FAIL random cycle %0d got v=%h c%b b%b r%b d%b want v=%h c%b b%b r%b d%b",
                        n, value, carry, borrow, running, done,
                        m_value, m_carry, m_borrow, m_state == M_RUN, m_state == M_DONE);
            end
         end
      end
      rst_n = 1'b1;
      tick = 1'b0;
   endtask

   initial begin
      m_value = '0; m_state = M_IDLE; m_carry = 1'b0; m_borrow = 1'b0;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_one_shot();
      test_pause();
      test_reset_and_load_priority();
      test_above_limit();
      // Bring the model into a known agreement with the DUT before random run.
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
